// File: rtl/ram_param.sv
// Parametrised word-register RAM with selectable combinational/registered read and a
// one-word-per-cycle hardware clear engine. Contents reset asynchronously, so no vendor RAM.
module ram_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned REG_READ = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic              busy,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // One write port shared by user writes and the clear sweep; clr beats load in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = data_in;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = ptr_q;
      wr_data = '0;
    end else if (load && !clr) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == LastAddr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign busy = busy_q;

  if (REG_READ != 0) begin : g_reg_read
    logic [DATA_W-1:0] rd_q;

    // Write-first: a write to the addressed word (including a clear zeroing) is forwarded.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else if (wr_en && (wr_addr == address)) begin
        rd_q <= wr_data;
      end else begin
        rd_q <= mem_q[address];
      end
    end

    assign data_out = rd_q;
  end else begin : g_comb_read
    assign data_out = mem_q[address];
  end

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: three instances (8-word comb, 8-word registered, 64-word comb) share
// stimulus and are checked each cycle against a behavioural array model.
module tb_ram_param;

  localparam int unsigned DataW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic             clr = 1'b0;
  logic [5:0]       address = '0;
  logic [DataW-1:0] data_in = '0;

  logic             busy_c8, busy_r8, busy_c64;
  logic [DataW-1:0] dout_c8, dout_r8, dout_c64;

  always #5 clk = ~clk;

  ram_param #(.DATA_W(DataW), .ADDR_W(3), .REG_READ(0)) u_c8 (
    .clk(clk), .rst(rst), .load(load), .address(address[2:0]), .data_in(data_in),
    .clr(clr), .busy(busy_c8), .data_out(dout_c8)
  );

  ram_param #(.DATA_W(DataW), .ADDR_W(3), .REG_READ(1)) u_r8 (
    .clk(clk), .rst(rst), .load(load), .address(address[2:0]), .data_in(data_in),
    .clr(clr), .busy(busy_r8), .data_out(dout_r8)
  );

  ram_param #(.DATA_W(DataW), .ADDR_W(6), .REG_READ(0)) u_c64 (
    .clk(clk), .rst(rst), .load(load), .address(address), .data_in(data_in),
    .clr(clr), .busy(busy_c64), .data_out(dout_c64)
  );

  // Behavioural model: arrays, a busy flag and a count of clear cycles done.
  logic [DataW-1:0] m8 [8];
  logic [DataW-1:0] m64 [64];
  bit               mb8, mb64;
  int               mn8, mn64;
  logic [DataW-1:0] mr8;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m8[i] = '0;
    for (int i = 0; i < 64; i++) m64[i] = '0;
    mb8 = 1'b0;
    mb64 = 1'b0;
    mn8 = 0;
    mn64 = 0;
    mr8 = '0;
  endfunction

  // Apply one rising edge to the model using the inputs currently held.
  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (mb8) begin
      m8[mn8] = '0;
      mn8++;
      if (mn8 == 8) mb8 = 1'b0;
    end else if (clr) begin
      mb8 = 1'b1;
      mn8 = 0;
    end else if (load) begin
      m8[address[2:0]] = data_in;
    end
    mr8 = m8[address[2:0]];
    if (mb64) begin
      m64[mn64] = '0;
      mn64++;
      if (mn64 == 64) mb64 = 1'b0;
    end else if (clr) begin
      mb64 = 1'b1;
      mn64 = 0;
    end else if (load) begin
      m64[address] = data_in;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_c8", busy_c8, mb8);
      check("busy_r8", busy_r8, mb8);
      check("busy_c64", busy_c64, mb64);
      check("dout_c8", dout_c8, m8[address[2:0]]);
      check("dout_r8", dout_r8, mr8);
      check("dout_c64", dout_c64, m64[address]);
    end
  end

  // Inputs change 2 time units after each rising edge and hold through the next one.
  task automatic cycle(input bit ld, input logic [5:0] a, input logic [DataW-1:0] d,
                       input bit c);
    load = ld;
    address = a;
    data_in = d;
    clr = c;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic run_clear(input int load_at, input bit clr_pulses, output int n8,
                           output int n64);
    int n;
    n = 0;
    n8 = 0;
    n64 = 0;
    while ((busy_c8 || busy_c64) && n < 200) begin
      n++;
      if (n == load_at) cycle(1'b1, 6'd7, 16'h5555, 1'b0);
      else cycle(1'b0, 6'(n - 1), '0, clr_pulses && n[0]);
      if (!busy_c8 && n8 == 0) n8 = n;
      if (!busy_c64 && n64 == 0) n64 = n;
    end
  endtask

  initial begin
    int n8, n64;
    logic [DataW-1:0] exp;

    rst = 1'b1;
    model_reset();
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Write / readback
    cycle(1'b1, 6'd5, 16'hA5A5, 1'b0);
    cycle(1'b1, 6'd2, 16'h1234, 1'b0);
    check("model_pin_m8_5", m8[5], 16'hA5A5);
    check("rd_r8_write_first_2", dout_r8, 16'h1234);
    address = 6'd5;
    #1;
    check("rd_c8_5", dout_c8, 16'hA5A5);
    check("rd_c64_5", dout_c64, 16'hA5A5);
    check("rd_r8_lat_hold", dout_r8, 16'h1234);
    cycle(1'b0, 6'd5, '0, 1'b0);
    check("rd_r8_5_after_edge", dout_r8, 16'hA5A5);
    for (int a = 0; a < 8; a++) begin
      cycle(1'b0, 6'(a), '0, 1'b0);
      exp = (a == 5) ? 16'hA5A5 : (a == 2) ? 16'h1234 : 16'h0000;
      check("sweep_c8", dout_c8, exp);
    end
    cycle(1'b1, 6'd3, 16'h00FF, 1'b0);
    check("rd_r8_write_first_3", dout_r8, 16'h00FF);

    // Asynchronous reset mid-cycle
    cycle(1'b0, 6'd5, '0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy_c8", busy_c8, 0);
    check("rst_dout_c8", dout_c8, 0);
    check("rst_dout_r8", dout_r8, 0);
    check("rst_dout_c64", dout_c64, 0);
    cycle(1'b1, 6'd2, 16'h9999, 1'b0);
    cycle(1'b0, 6'd2, '0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 6'd2, '0, 1'b0);
    check("post_rst_c8_2", dout_c8, 0);

    // Clear of a full array, with a load at cycle 3 that must be ignored
    for (int a = 0; a < 8; a++) cycle(1'b1, 6'(a), 16'hFFFF, 1'b0);
    cycle(1'b0, 6'd0, '0, 1'b1);
    check("clr_busy_c8", busy_c8, 1);
    check("clr_busy_c64", busy_c64, 1);
    run_clear(3, 1'b0, n8, n64);
    check("clr_len_8", n8, 8);
    check("clr_len_64", n64, 64);
    for (int a = 0; a < 8; a++) begin
      cycle(1'b0, 6'(a), '0, 1'b0);
      check("post_clr_c8", dout_c8, 0);
    end

    // clr + load in the same cycle, then clr pulses during busy
    cycle(1'b1, 6'd0, 16'h1111, 1'b0);
    cycle(1'b1, 6'd0, 16'h7777, 1'b1);
    check("clr_load_dropped", dout_c8, 16'h1111);
    check("clr_load_busy", busy_c8, 1);
    run_clear(0, 1'b1, n8, n64);
    check("clr_pulse_len_8", n8, 8);
    check("clr_pulse_len_64", n64, 64);

    // Reset during a clear
    cycle(1'b1, 6'd6, 16'hCAFE, 1'b0);
    cycle(1'b0, 6'd0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'd6, '0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_clr_busy_c8", busy_c8, 0);
    check("rst_clr_busy_r8", busy_r8, 0);
    check("rst_clr_busy_c64", busy_c64, 0);
    cycle(1'b0, 6'd6, '0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 6'd6, '0, 1'b0);
    check("rst_clr_c8_6", dout_c8, 0);
    cycle(1'b1, 6'd4, 16'h4321, 1'b0);
    check("rst_clr_wr_c8", dout_c8, 16'h4321);
    check("rst_clr_wr_c64", dout_c64, 16'h4321);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1'b1;
        model_reset();
        cycle(1'b0, 6'($urandom), '0, 1'b0);
        rst = 1'b0;
      end else begin
        cycle(1'($urandom_range(0, 1)), 6'($urandom), 16'($urandom), r < 6);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
